// File: rtl/seq_bin2bcd_pkg.sv
// Shared definitions for the product-to-BCD path: controller states, default
// widths and the double-dabble digit adjust constants.
package seq_bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_DEF = 11;
    localparam int D_DEF = 4;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_INC    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more is bumped by 3 so
// that the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import seq_bin2bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= ADJ_THRESH) ? (d_i + ADJ_INC) : d_i;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Sits after the product register; bcd/done feed the 7-segment decoders.
module seq_bin2bcd
    import seq_bin2bcd_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int D = D_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   bin,
    output logic [4*D-1:0] bcd,
    output logic           busy,
    output logic           done
);

    localparam int             CW   = $clog2(N + 1);
    localparam int             W    = 4 * D + N;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [4*D-1:0] scr_q, scr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4*D-1:0] bcd_q, bcd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [4*D-1:0] adj;
    logic [W-1:0]   shifted;

    for (genvar k = 0; k < D; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (scr_q[4*k +: 4]),
            .d_o (adj[4*k +: 4])
        );
    end

    // Correct first, then shift the combined scratch:binary register by one.
    assign shifted = {adj, sr_q} << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sr_d    = bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scr_d = shifted[W-1 -: 4*D];
                sr_d  = shifted[N-1:0];
                cnt_d = cnt_q + CW'(1);
                // Last bit shifted in: the scratch now holds the final digits.
                if (cnt_q == LAST) begin
                    bcd_d   = shifted[W-1 -: 4*D];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Bench for seq_bin2bcd: vector table, multi-cycle corner sequences and an
// exhaustive sweep, checked through an expected-result queue.
module tb_seq_bin2bcd;

    localparam int N = 11;
    localparam int D = 4;

    typedef struct {
        logic [N-1:0] bin;
        logic [15:0]  exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   bin = '0;
    logic [4*D-1:0] bcd;
    logic           busy;
    logic           done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    vec_t tbl[10];

    seq_bin2bcd #(.N(N), .D(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done && busy) begin
            total++;
            bad++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b expected not both high", busy, done);
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: bcd=0x%0h with no result expected", bcd);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("bcd_result", 32'(bcd), 32'(mon_exp));
            end
        end
    end

    task automatic run_one(input logic [N-1:0] v, input logic [15:0] e, input bit chk_lat);
        int lat;
        int bsy;
        bit seen;
        exp_q.push_back(e);
        bin   = v;
        start = 1'b1;
        lat   = 0;
        bsy   = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else if (busy) begin
                bsy++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: bin=%0d no done within 40 edges", v);
            exp_q.delete();
        end else if (chk_lat) begin
            chk("done_latency", 32'(lat), 32'd11);
            chk("busy_cycles", 32'(bsy), 32'd11);
        end
    endtask

    initial begin
        int d0;
        int lat1;
        int lat2;

        tbl[0] = '{11'd0,    16'h0000};
        tbl[1] = '{11'd256,  16'h0256};
        tbl[2] = '{11'd2047, 16'h2047};
        tbl[3] = '{11'd16,   16'h0016};
        tbl[4] = '{11'd1,    16'h0001};
        tbl[5] = '{11'd9,    16'h0009};
        tbl[6] = '{11'd10,   16'h0010};
        tbl[7] = '{11'd999,  16'h0999};
        tbl[8] = '{11'd1000, 16'h1000};
        tbl[9] = '{11'd1234, 16'h1234};

        // Held in reset with start asserted: outputs must stay at reset values.
        start = 1'b1;
        bin   = 11'd2047;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        start = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++)
            run_one(tbl[i].bin, tbl[i].exp, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // start and bin change during SHIFT are ignored.
        d0 = done_cnt;
        lat1 = -1;
        exp_q.push_back(16'h0123);
        bin   = 11'd123;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            if (i == 3) begin
                start = 1'b1;
                bin   = 11'd99;
            end
            if (i == 6) start = 1'b0;
            if (done) lat1 = i;
        end
        chk("busy_ignore_done_count", 32'(done_cnt - d0), 32'd1);
        chk("busy_ignore_latency", 32'(lat1), 32'd11);

        // Back-to-back: start held through the DONE cycle.
        d0 = done_cnt;
        lat1 = -1;
        lat2 = -1;
        exp_q.push_back(16'h0500);
        exp_q.push_back(16'h0007);
        bin   = 11'd500;
        start = 1'b1;
        for (int i = 0; i < 40 && lat2 < 0; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) bin = 11'd7;
            if (i == 12) start = 1'b0;
            if (done) begin
                if (lat1 < 0) lat1 = i;
                else lat2 = i;
            end
        end
        start = 1'b0;
        chk("b2b_first_done_edge", 32'(lat1), 32'd11);
        chk("b2b_second_done_edge", 32'(lat2), 32'd23);
        @(posedge clk);
        #1;
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // Reset in the middle of a conversion.
        d0 = done_cnt;
        bin   = 11'd321;
        start = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_bcd", 32'(bcd), 32'h0);
        chk("midrst_hold_busy", 32'(busy), 32'h0);
        start = 1'b0;
        #2 rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_one(11'd42, 16'h0042, 1'b1);

        for (int v = 0; v < 2048; v++)
            run_one(11'(v), ref_bcd(v), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
